// File: rtl/shift_pack_ctrl.sv
// Stream packer: shifts WIDTH-bit words into an NUM-word group (newest word in slot 0)
// and hands the group off over valid/ready. Optional partial-group flush: SHIFT_PACK_FLUSH_EN.
module shift_pack_ctrl #(
   parameter int NUM   = 4,
   parameter int WIDTH = 16,
   localparam int CW   = $clog2(NUM + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
`ifdef SHIFT_PACK_FLUSH_EN
   input  logic                   flush,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH*NUM-1:0]   out_data,
   output logic [CW-1:0]          out_count,
   output logic                   busy
);

   typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

   localparam logic [CW-1:0] NUM_C = CW'(NUM);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   state_t                 state, state_nxt;
   logic [WIDTH*NUM-1:0]   buff, buff_nxt, in_ext;
   logic [CW-1:0]          cnt, cnt_nxt, cnt_inc, fill_cnt, out_count_nxt;
   logic                   accept, group_done, flush_req;

   assign accept     = in_valid & in_ready;
   assign cnt_inc    = cnt + ONE_C;
   assign fill_cnt   = accept ? cnt_inc : cnt;
   assign group_done = accept && (cnt_inc == NUM_C);

   // A flush only closes a group that holds at least one word, counting this cycle's accept.
`ifdef SHIFT_PACK_FLUSH_EN
   assign flush_req = flush & (fill_cnt != '0);
`else
   assign flush_req = 1'b0;
`endif

   always_comb begin
      in_ext             = '0;
      in_ext[WIDTH-1:0]  = in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FILL;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == FILL) begin
         if (group_done || flush_req) state_nxt = FULL;
      end else begin
         // With NUM==1 a word taken during hand-off is itself a complete group.
         if (out_ready && !(accept && NUM == 1)) state_nxt = FILL;
      end
   end

   always_comb begin
      in_ready = 1'b0;
      if (rst_n) in_ready = (state == FILL) ? 1'b1 : out_ready;
   end

   always_comb begin
      buff_nxt      = buff;
      cnt_nxt       = cnt;
      out_count_nxt = out_count;
      if (state == FILL) begin
         if (accept) buff_nxt = (buff << WIDTH) | in_ext;
         if (group_done) begin
            cnt_nxt       = '0;
            out_count_nxt = NUM_C;
         end else if (flush_req) begin
            cnt_nxt       = '0;
            out_count_nxt = fill_cnt;
         end else begin
            cnt_nxt = fill_cnt;
         end
      end else if (out_ready) begin
         // Hand-off clears stale slots so a following partial group reads zero above its words.
         buff_nxt = accept ? in_ext : '0;
         cnt_nxt  = (accept && NUM != 1) ? ONE_C : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buff      <= '0;
         cnt       <= '0;
         out_count <= '0;
      end else begin
         buff      <= buff_nxt;
         cnt       <= cnt_nxt;
         out_count <= out_count_nxt;
      end
   end

   assign out_valid = (state == FULL);
   assign out_data  = buff;
   assign busy      = (cnt != '0) | out_valid;

endmodule

// File: tb/tb_shift_pack_ctrl.sv
// Directed self-checking bench for shift_pack_ctrl (NUM=4 instance plus a NUM=1 instance).
module tb_shift_pack_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, out_ready;
   logic        in_ready, out_valid, busy;
   logic [15:0] in_data;
   logic [63:0] out_data;
   logic [2:0]  out_count;
`ifdef SHIFT_PACK_FLUSH_EN
   logic        flush;
`endif

   logic        in_valid1, out_ready1;
   logic        in_ready1, out_valid1, busy1;
   logic [15:0] in_data1;
   logic [15:0] out_data1;
   logic [0:0]  out_count1;

   int n_chk  = 0;
   int n_fail = 0;
   int groups;
   logic [15:0] w [0:11];

   always #5 clk = ~clk;

   shift_pack_ctrl #(.NUM(4), .WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data),
`ifdef SHIFT_PACK_FLUSH_EN
      .flush(flush),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_count(out_count), .busy(busy)
   );

   shift_pack_ctrl #(.NUM(1), .WIDTH(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_data(in_data1),
`ifdef SHIFT_PACK_FLUSH_EN
      .flush(1'b0),
`endif
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .out_count(out_count1), .busy(busy1)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic feed(input logic [15:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
`ifdef SHIFT_PACK_FLUSH_EN
      flush = 1'b0;
`endif
      tick(); tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data",  out_data, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_busy",      busy, 0);
      chk("rst_in_ready",  in_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // Basic group with consumer ready
      feed(16'h1111); feed(16'h2222); feed(16'h3333);
      chk("partial_no_valid", out_valid, 0);
      chk("partial_busy", busy, 1);
      feed(16'h4444);
      chk("grp1_valid", out_valid, 1);
      chk("grp1_data",  out_data, 64'h1111_2222_3333_4444);
      chk("grp1_count", out_count, 4);
      in_valid = 1'b0;
      tick();
      chk("grp1_drop_valid", out_valid, 0);
      chk("grp1_cleared",    out_data, 0);
      chk("grp1_idle_busy",  busy, 0);

      // Backpressure, then hand-off with a simultaneous accept
      out_ready = 1'b0;
      feed(16'h0005); feed(16'h0006); feed(16'h0007); feed(16'h0008);
      in_valid = 1'b1; in_data = 16'hBBBB;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_in_ready", in_ready, 0);
         tick();
         chk("bp_valid", out_valid, 1);
         chk("bp_data",  out_data, 64'h0005_0006_0007_0008);
      end
      out_ready = 1'b1; in_data = 16'hAAAA;
      #1;
      chk("handoff_in_ready", in_ready, 1);
      tick();
      chk("handoff_valid", out_valid, 0);
      chk("handoff_buff",  out_data, 64'h0000_0000_0000_AAAA);
      chk("handoff_busy",  busy, 1);
      feed(16'h000B); feed(16'h000C); feed(16'h000D);
      chk("after_handoff_valid", out_valid, 1);
      chk("after_handoff_data",  out_data, 64'hAAAA_000B_000C_000D);
      in_valid = 1'b0;
      tick();

      // Sustained 12-word stream
      groups = 0;
      for (int i = 0; i < 12; i++) begin
         w[i] = 16'h0100 + 16'(i);
         in_valid = 1'b1; in_data = w[i];
         #1;
         chk("stream_in_ready", in_ready, 1);
         tick();
         chk("stream_valid", out_valid, ((i % 4) == 3));
         if ((i % 4) == 3) begin
            groups++;
            chk("stream_data", out_data, {w[i-3], w[i-2], w[i-1], w[i]});
            chk("stream_count", out_count, 4);
         end
      end
      in_valid = 1'b0;
      tick();
      chk("stream_groups", groups, 3);
      chk("stream_drained", out_valid, 0);

`ifdef SHIFT_PACK_FLUSH_EN
      feed(16'h0001); feed(16'h0002);
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_valid", out_valid, 1);
      chk("flush_data",  out_data, 64'h0000_0000_0001_0002);
      chk("flush_count", out_count, 2);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_empty_valid", out_valid, 0);
`endif

      // Asynchronous reset mid-group discards partial data
      feed(16'h0E01); feed(16'h0E02); feed(16'h0E03);
      in_valid = 1'b0;
      chk("pre_reset_data", out_data, 64'h0000_0E01_0E02_0E03);
      rst_n = 1'b0;
      #1;
      chk("async_rst_data",     out_data, 0);
      chk("async_rst_busy",     busy, 0);
      chk("async_rst_in_ready", in_ready, 0);
      chk("async_rst_valid",    out_valid, 0);
      #2;
      rst_n = 1'b1;
      tick();
      feed(16'h0F01); feed(16'h0F02); feed(16'h0F03); feed(16'h0F04);
      chk("clean_grp_valid", out_valid, 1);
      chk("clean_grp_data",  out_data, 64'h0F01_0F02_0F03_0F04);
      in_valid = 1'b0;
      tick();

      // NUM=1 instance: every word is a complete group
      in_valid1 = 1'b1; in_data1 = 16'h1234;
      tick();
      chk("n1_valid_a", out_valid1, 1);
      chk("n1_data_a",  out_data1, 16'h1234);
      chk("n1_count_a", out_count1, 1);
      in_data1 = 16'h5678;
      #1;
      chk("n1_in_ready", in_ready1, 1);
      tick();
      chk("n1_valid_b", out_valid1, 1);
      chk("n1_data_b",  out_data1, 16'h5678);
      in_valid1 = 1'b0;
      tick();
      chk("n1_drop_valid", out_valid1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
